alu_share_arbiter: RTL

- Shares one combinational 32-bit ALU between two requesters: port 0 is the main pipeline EX stage, port 1 is the auxiliary address/loop unit.
- Arbitrates round-robin, latches the granted operands, drives the shared ALU, and returns a registered result and Zero flag to the winner.
- Uses valid/ready handshakes on both sides.
- Sits between the requesters and the single ALU32Bit instance.

---
 rtl/alu_share_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between the EX stage (port 0) and the aux unit (port 1).
// Grants in IDLE, drives the latched operands through EXEC, and holds a registered result in RESP.
module alu_share_arbiter #(
  parameter int                 WIDTH      = 32,
  parameter int                 CTRL_W     = 4,
  parameter logic [CTRL_W-1:0]  MUL_CODE   = CTRL_W'(2),
  parameter int                 MUL_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [WIDTH-1:0]  rsp0_result,
  output logic              rsp0_zero,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [WIDTH-1:0]  rsp1_result,
  output logic              rsp1_zero,
  output logic [CTRL_W-1:0] alu_control,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int               CNT_W    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  logic [1:0]        r_state;
  logic              r_last_grant;
  logic              r_id;
  logic [CNT_W-1:0]  r_cnt;
  logic [CTRL_W-1:0] r_ctrl;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_res;
  logic              r_zero;

  logic              w_idle;
  logic              w_any_valid;
  logic              w_grant_id;
  logic [CTRL_W-1:0] w_sel_ctrl;
  logic              w_rsp_hs;

  assign w_idle      = (r_state == S_IDLE);
  assign w_any_valid = req0_valid | req1_valid;
  // On a tie the requester that was not served last wins; otherwise whoever is valid.
  assign w_grant_id  = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
  assign w_sel_ctrl  = w_grant_id ? req1_ctrl : req0_ctrl;

  assign req0_ready = Reset_n & w_idle & req0_valid & ~w_grant_id;
  assign req1_ready = Reset_n & w_idle & req1_valid &  w_grant_id;

  assign rsp0_valid  = (r_state == S_RESP) & ~r_id;
  assign rsp1_valid  = (r_state == S_RESP) &  r_id;
  assign rsp0_result = rsp0_valid ? r_res : '0;
  assign rsp1_result = rsp1_valid ? r_res : '0;
  assign rsp0_zero   = rsp0_valid & r_zero;
  assign rsp1_zero   = rsp1_valid & r_zero;
  assign w_rsp_hs    = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);

  assign alu_control = r_ctrl;
  assign alu_a       = r_a;
  assign alu_b       = r_b;
  assign busy        = ~w_idle;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_cnt        <= '0;
      r_ctrl       <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_res        <= '0;
      r_zero       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_valid) begin
            r_id    <= w_grant_id;
            r_ctrl  <= w_sel_ctrl;
            r_a     <= w_grant_id ? req1_a : req0_a;
            r_b     <= w_grant_id ? req1_b : req0_b;
            r_cnt   <= (w_sel_ctrl == MUL_CODE) ? MUL_LOAD : '0;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_cnt == '0) begin
            r_res   <= alu_result;
            r_zero  <= alu_zero;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (w_rsp_hs) begin
            r_last_grant <= r_id;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
